// File: rtl/nibble_packer.sv
// rtl/nibble_packer.sv - packs accepted 4-bit nibbles into 16-bit words, first nibble in [3:0].
// A word can be closed early with flush, padding the unfilled upper slots with PAD.
module nibble_packer #(
    parameter logic [3:0] PAD = 4'h0
) (
    input  logic        clk,
    input  logic        nrst,
    input  logic [3:0]  in_data,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        flush,
    output logic [15:0] out_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [2:0]  count
);

    typedef enum logic {
        FILL = 1'b0,
        FULL = 1'b1
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [15:0] word_nxt;
    logic [2:0]  count_nxt;
    logic        accept;
    int          pad_from;

    // While a word is held, a new nibble is taken only in the handoff cycle.
    assign in_ready = (state == FILL) ? 1'b1 : out_ready;
    assign accept   = in_valid && in_ready;

    always_comb begin
        state_nxt = state;
        word_nxt  = out_data;
        count_nxt = count;
        pad_from  = 4;
        if (state == FILL) begin
            if (accept) begin
                word_nxt[4*count[1:0] +: 4] = in_data;
                if (count == 3'd3 || flush) begin
                    pad_from  = int'(count) + 1;
                    state_nxt = FULL;
                    count_nxt = 3'd4;
                end else begin
                    count_nxt = count + 3'd1;
                end
            end else if (flush && count != 3'd0) begin
                pad_from  = int'(count);
                state_nxt = FULL;
                count_nxt = 3'd4;
            end
        end else begin
            if (out_ready) begin
                state_nxt = FILL;
                if (in_valid) begin
                    word_nxt[3:0] = in_data;
                    count_nxt     = 3'd1;
                end else begin
                    count_nxt     = 3'd0;
                end
            end
        end
        for (int i = 0; i < 4; i++) begin
            if (i >= pad_from) begin
                word_nxt[4*i +: 4] = PAD;
            end
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state     <= FILL;
            out_data  <= 16'h0000;
            count     <= 3'd0;
            out_valid <= 1'b0;
        end else begin
            state     <= state_nxt;
            out_data  <= word_nxt;
            count     <= count_nxt;
            out_valid <= (state_nxt == FULL);
        end
    end

endmodule

// File: doc/nibble_packer.md
NIBBLE_PACKER -- requirements
Module: nibble_packer

Interface
REQ-001 Parameter PAD, default 4'h0: nibble value written into unfilled slots on flush.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 nrst  input  1  reset, asynchronous, active-low.
REQ-004 in_data  input  4  incoming nibble.
REQ-005 in_valid  input  1  in_data valid this cycle.
REQ-006 in_ready  output  1  block accepts nibble this cycle; transfer when in_valid && in_ready.
REQ-007 flush  input  1  close the partial word early, padding remaining slots with PAD.
REQ-008 out_data  output  16  packed word for the downstream 4-nibble sorter; meaningful only while out_valid=1.
REQ-009 out_valid  output  1  out_data holds a complete word.
REQ-010 out_ready  input  1  downstream takes word; transfer when out_valid && out_ready.
REQ-011 count  output  3  nibbles held: 0..3 in FILL, 4 in FULL.

Function
REQ-012 Two states SHALL exist: FILL (collecting, out_valid=0) and FULL (word held, out_valid=1); out_valid and count SHALL be registered.
REQ-013 Packing order SHALL be k-th accepted nibble (k=0..3) into out_data[4k+3:4k]; first nibble lands in [3:0], fourth in [15:12].
REQ-014 in_ready SHALL be 1 in FILL, and in FULL equal to out_ready (combinational from out_ready only).
REQ-015 FILL, accept with count<3: write slot[count], count+1, stay FILL.
REQ-016 FILL, accept with count=3: write slot[3], go FULL next cycle, count=4, out_valid=1; latency from 4th accepted nibble to out_valid = 1 cycle.
REQ-017 FULL: out_data and out_valid SHALL remain stable until out_ready=1; in_ready=0 while out_ready=0.
REQ-018 FULL with out_ready=1 and in_valid=0: go FILL, count=0.
REQ-019 FULL with out_ready=1 and in_valid=1: word handed off and nibble written to slot[0] in the same cycle; go FILL, count=1 (no bubble).
REQ-020 flush in FILL with count=c>0 and no accept: slots c..3 SHALL be written PAD, go FULL next cycle.
REQ-021 flush coincident with accept in FILL: nibble written at slot[count] first, remaining higher slots padded with PAD; if it was the 4th nibble, the result is an ordinary word and no extra word is produced.
REQ-022 flush with count=0 and no accept: ignored; flush in FULL: ignored.
REQ-023 Slots not yet written in FILL SHALL retain stale content; only out_valid=1 qualifies out_data.
REQ-024 No nibble SHALL ever be dropped or duplicated; accepted nibbles appear in exactly one output word in arrival order.

Reset
REQ-025 nrst=0 SHALL immediately (without clock) force state FILL, count=0, out_valid=0, out_data=16'h0000; in_ready=1 while held in reset is permitted but no transfer SHALL be registered.
REQ-026 Reset mid-fill or mid-hold SHALL discard the partial/held word; first nibble after release goes to slot[0].

Verification
REQ-027 Nibbles 1,2,3,4 on consecutive cycles, out_ready=1 -> out_valid=1 one cycle after 4th accept, out_data=16'h4321, count=4.
REQ-028 Word 16'h4321 held, out_ready=0 for 3 cycles with in_valid=1, in_data=4'hA -> in_ready=0, out_data stable; then out_ready=1 -> handoff and next cycle count=1, slot[0]=A.
REQ-029 Nibbles 5,6 then flush, PAD=0 -> out_data=16'h0065, out_valid=1, count=4.
REQ-030 Flush asserted with 4th nibble (1,2,3,4) -> single word 16'h4321, next cycle after handoff count=0, no second word.
REQ-031 nrst pulsed low at count=2 -> count=0, out_valid=0 asynchronously; then 7,8,9,A -> out_data=16'hA987.
REQ-032 flush at count=0 with in_valid=0 -> no state change, out_valid stays 0.
